// File: rtl/load_store_unit_if.sv
// Word-aligned memory bus between the load/store unit (master) and a data memory (slave).
// A request is held until the memory acknowledges it; read data is valid with the ack.
interface load_store_unit_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_ack;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-lane steering for stores, lane select and extension for loads.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of truncating the address.
module load_store_unit #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [DWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DWIDTH-1:0] load_data,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e            state_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              legal;
  logic [3:0]        strb_d;
  logic [DWIDTH-1:0] wdata_d;
  logic [DWIDTH-1:0] rshift;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DWIDTH-1:0] ld_ext;

  always_comb begin
    if (is_store) begin
      legal = funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
`ifdef MISALIGN_TRAP_EN
    // funct3[1:0] == 01 is any halfword, 10 is any word access
    if (funct3[1:0] == 2'b01 && addr[0]) legal = 1'b0;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) legal = 1'b0;
`endif
  end

  always_comb begin
    strb_d  = 4'b0000;
    wdata_d = '0;
    if (is_store) begin
      unique case (funct3[1:0])
        2'b00: begin
          strb_d  = 4'b0001 << addr[1:0];
          wdata_d = {4{wdata[7:0]}};
        end
        2'b01: begin
          strb_d  = addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{wdata[15:0]}};
        end
        default: begin
          strb_d  = 4'b1111;
          wdata_d = wdata;
        end
      endcase
    end
  end

  always_comb begin
    rshift    = mem.mem_rdata >> {off_q, 3'b000};
    byte_lane = rshift[7:0];
    half_lane = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    unique case (f3_q)
      3'b000:  ld_ext = {{(DWIDTH-8){byte_lane[7]}}, byte_lane};
      3'b001:  ld_ext = {{(DWIDTH-16){half_lane[15]}}, half_lane};
      3'b100:  ld_ext = {{(DWIDTH-8){1'b0}}, byte_lane};
      3'b101:  ld_ext = {{(DWIDTH-16){1'b0}}, half_lane};
      default: ld_ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      load_data     <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= 4'b0000;
      mem.mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            f3_q  <= funct3;
            off_q <= addr[1:0];
            if (legal) begin
              state_q       <= StReq;
              busy          <= 1'b1;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= is_store;
              mem.mem_addr  <= {addr[DWIDTH-1:2], 2'b00};
              mem.mem_wstrb <= strb_d;
              mem.mem_wdata <= wdata_d;
            end else begin
              state_q <= StErr;
              done    <= 1'b1;
              err     <= 1'b1;
            end
          end
        end
        StReq: begin
          if (mem.mem_ack) begin
            state_q     <= StDone;
            busy        <= 1'b0;
            done        <= 1'b1;
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) load_data <= ld_ext;
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one transaction per vector with hand-computed bus and load
// values, plus reset-state and reset-during-request checks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  int          n_cmp = 0;
  int          n_bad = 0;

  load_store_unit_if #(.DWIDTH(32)) bus ();

  load_store_unit #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .mem       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request; mem_ack rises after `delay` extra REQ cycles. Starts issued while busy
  // and during the done cycle must be dropped.
  task automatic run_txn(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int delay, input logic exp_err, input logic [31:0] exp_maddr,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                         input logic [31:0] exp_ld);
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    if (exp_err) begin
      check_eq({name, ".done"}, 32'(done), 32'd1);
      check_eq({name, ".err"}, 32'(err), 32'd1);
      check_eq({name, ".req"}, 32'(bus.mem_req), 32'd0);
      check_eq({name, ".busy"}, 32'(busy), 32'd0);
      check_eq({name, ".ld"}, load_data, exp_ld);
      @(negedge clk);
      check_eq({name, ".req2"}, 32'(bus.mem_req), 32'd0);
      check_eq({name, ".done2"}, 32'(done), 32'd0);
    end else begin
      for (int i = 0; i <= delay; i++) begin
        check_eq({name, ".req"}, 32'(bus.mem_req), 32'd1);
        check_eq({name, ".busy"}, 32'(busy), 32'd1);
        check_eq({name, ".early_done"}, 32'(done), 32'd0);
        check_eq({name, ".we"}, 32'(bus.mem_we), 32'(st));
        check_eq({name, ".maddr"}, bus.mem_addr, exp_maddr);
        check_eq({name, ".wstrb"}, 32'(bus.mem_wstrb), 32'(exp_strb));
        check_eq({name, ".mwdata"}, bus.mem_wdata, exp_wd);
        if (i == delay) begin
          start = 1'b0;
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rd;
        end else begin
          start = 1'b1; is_store = ~st; funct3 = 3'b000; addr = 32'hFFFF_FFFF;
          wdata = 32'h5A5A_5A5A;
        end
        @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'hDEAD_0000;
      check_eq({name, ".done"}, 32'(done), 32'd1);
      check_eq({name, ".err"}, 32'(err), 32'd0);
      check_eq({name, ".busy_end"}, 32'(busy), 32'd0);
      check_eq({name, ".req_end"}, 32'(bus.mem_req), 32'd0);
      check_eq({name, ".ld"}, load_data, exp_ld);
      start = 1'b1; is_store = st; funct3 = f3; addr = a;
      @(negedge clk);
      start = 1'b0;
      check_eq({name, ".done_once"}, 32'(done), 32'd0);
      check_eq({name, ".drop_in_done"}, 32'(bus.mem_req), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mis_ld;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    #3;
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.err", 32'(err), 32'd0);
    check_eq("rst.req", 32'(bus.mem_req), 32'd0);
    check_eq("rst.we", 32'(bus.mem_we), 32'd0);
    check_eq("rst.maddr", bus.mem_addr, 32'd0);
    check_eq("rst.wstrb", 32'(bus.mem_wstrb), 32'd0);
    check_eq("rst.mwdata", bus.mem_wdata, 32'd0);
    check_eq("rst.ld", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 0,
            1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
    run_txn("sh", 1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h0, 0,
            1'b0, 32'h20, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80);
    run_txn("lw_wait", 1'b0, 3'b010, 32'h200, 32'h0, 32'hDEAD_BEEF, 3,
            1'b0, 32'h200, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    run_txn("sb", 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 32'h0, 1,
            1'b0, 32'h10, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    run_txn("lbu", 1'b0, 3'b100, 32'h101, 32'h0, 32'h1234_5678, 0,
            1'b0, 32'h100, 4'b0000, 32'h0, 32'h0000_0056);
    run_txn("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 0,
            1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_8001);
    run_txn("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234_F00D, 0,
            1'b0, 32'h100, 4'b0000, 32'h0, 32'h0000_F00D);
    run_txn("sw", 1'b1, 3'b010, 32'h40, 32'hCAFE_BABE, 32'h0, 0,
            1'b0, 32'h40, 4'b1111, 32'hCAFE_BABE, 32'h0000_F00D);
`ifdef MISALIGN_TRAP_EN
    mis_ld = 32'h0000_F00D;
    run_txn("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'h1122_3344, 0,
            1'b1, 32'h0, 4'b0000, 32'h0, mis_ld);
`else
    mis_ld = 32'h1122_3344;
    run_txn("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'h1122_3344, 0,
            1'b0, 32'h100, 4'b0000, 32'h0, mis_ld);
`endif
    run_txn("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0,
            1'b1, 32'h0, 4'b0000, 32'h0, mis_ld);
    run_txn("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0,
            1'b1, 32'h0, 4'b0000, 32'h0, mis_ld);

    // Reset in the middle of a pending request.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    start = 1'b0;
    check_eq("rreq.req", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rreq.req_async", 32'(bus.mem_req), 32'd0);
    check_eq("rreq.busy_async", 32'(busy), 32'd0);
    check_eq("rreq.maddr_async", bus.mem_addr, 32'd0);
    check_eq("rreq.ld_async", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check_eq("rreq.no_done", 32'(done), 32'd0);
    check_eq("rreq.no_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    check_eq("rreq.no_done2", 32'(done), 32'd0);
    check_eq("rreq.ld_kept", load_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: DWIDTH, 32, data and address width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request from the core; ignored while busy=1.
REQ-005 SHALL have port: is_store  input  1  1=store, 0=load; sampled with start.
REQ-006 SHALL have port: funct3  input  3  RV32I width/sign code; sampled with start.
REQ-007 SHALL have port: addr  input  DWIDTH  byte address; sampled with start.
REQ-008 SHALL have port: wdata  input  DWIDTH  store data, low bits used; sampled with start.
REQ-009 SHALL have port: busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: err  output  1  qualifies done; access rejected.
REQ-012 SHALL have port: load_data  output  DWIDTH  extended load result, feeding writeback-select input 2.
REQ-013 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out DWIDTH (bits[1:0]=0), mem_wstrb out 4, mem_wdata out DWIDTH, mem_ack in 1, mem_rdata in DWIDTH.

Function
REQ-014 SHALL implement FSM IDLE, REQ, DONE, ERR; IDLE->REQ on legal start, IDLE->ERR on rejected start, REQ->DONE on mem_ack=1, DONE->IDLE, ERR->IDLE.
REQ-015 SHALL accept loads with funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores with 000 SB, 001 SH, 010 SW; any other code is rejected.
REQ-016 SHALL hold mem_req=1 in REQ with mem_we, mem_addr, mem_wstrb, mem_wdata stable until the cycle mem_ack is sampled high; mem_req SHALL be 0 in every other state.
REQ-017 SHALL ignore mem_ack outside REQ.
REQ-018 SHALL latency: start in cycle N -> mem_req in N+1; mem_ack in cycle M -> done in M+1, so the minimum is 2 cycles.
REQ-019 SHALL drive mem_addr = {addr[31:2],2'b00}.
REQ-020 SHALL set mem_wstrb: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b0000.
REQ-021 SHALL replicate store data: SB byte x4, SH halfword x2, SW unchanged.
REQ-022 SHALL register load_data at the mem_ack edge from mem_rdata: byte lane addr[1:0], half lane addr[1], then sign-extend (LB, LH) or zero-extend (LBU, LHU); LW is passed through.
REQ-023 SHALL change load_data only on load completion; store completion and err leave it unchanged until the next load completes.
REQ-024 SHALL assert done=1 for exactly one cycle in DONE or ERR; err=1 only in ERR.
REQ-025 SHALL issue no memory request for a rejected access.
REQ-026 SHALL drop a start that arrives while busy=1 or in DONE/ERR, with no side effect.

Reset
REQ-027 SHALL on rst_n=0 immediately force IDLE and busy, done, err, mem_req, mem_we to 0, and mem_addr, mem_wstrb, mem_wdata, load_data to 0.
REQ-028 SHALL abandon any in-flight request on reset, with no done pulse; an ack after reset release SHALL be ignored.

Configuration
REQ-029 SHALL, with MISALIGN_TRAP_EN defined, reject LH/LHU/SH when addr[0]=1 and LW/SW when addr[1:0]!=0, going to ERR.
REQ-030 SHALL, without MISALIGN_TRAP_EN, perform misaligned accesses by ignoring the offending low address bits (half uses addr[1]; word uses none); err is then raised only for illegal funct3.

Verification
REQ-031 SHALL check LB: addr=0x103, mem_rdata=0x80FF7F01 -> mem_addr=0x100, load_data=0xFFFFFF80, done one cycle after ack.
REQ-032 SHALL check SH: addr=0x22, wdata=0x1234ABCD -> mem_wstrb=4'b1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-033 SHALL check LW with ack delayed 3 cycles -> mem_req and mem_addr stable 4 cycles; busy=1 throughout; load_data equals mem_rdata.
REQ-034 SHALL check LW addr=0x102 -> with MISALIGN_TRAP_EN: no mem_req, done=err=1 at N+1; without it: mem_addr=0x100, err=0.
REQ-035 SHALL check funct3=011 -> err=1, no mem_req; a start while busy -> ignored.
REQ-036 SHALL check rst_n=0 during REQ -> mem_req=0 immediately; a later ack -> no done.
